// File: rtl/game_pkg.sv
// Shared types and box-overlap arithmetic for the game-outcome controller.
package game_pkg;

  localparam int unsigned COORD_W = 10;

  typedef enum logic [1:0] {
    PLAY,
    DEATH,
    GAME_OVER,
    WIN
  } state_e;

  // Low edge saturates at zero so a sprite near the origin never wraps to the far side.
  function automatic logic [COORD_W:0] lo_edge(input logic [COORD_W-1:0] c,
                                               input logic [COORD_W-1:0] s);
    return (c >= s) ? {1'b0, c - s} : '0;
  endfunction

  function automatic logic [COORD_W:0] hi_edge(input logic [COORD_W-1:0] c,
                                               input logic [COORD_W-1:0] s);
    return {1'b0, c} + {1'b0, s};
  endfunction

  function automatic logic box_hit(input logic [COORD_W-1:0] xa, input logic [COORD_W-1:0] ya,
                                   input logic [COORD_W-1:0] sa, input logic [COORD_W-1:0] xb,
                                   input logic [COORD_W-1:0] yb, input logic [COORD_W-1:0] sb);
    return (lo_edge(xa, sa) <= hi_edge(xb, sb)) && (hi_edge(xa, sa) >= lo_edge(xb, sb)) &&
           (lo_edge(ya, sa) <= hi_edge(yb, sb)) && (hi_edge(ya, sa) >= lo_edge(yb, sb));
  endfunction

endpackage

// File: rtl/box_overlap.sv
// Combinational overlap test between two centre/half-size boxes; touching edges hit.
module box_overlap
  import game_pkg::*;
(
  input  logic [COORD_W-1:0] x_a_i,
  input  logic [COORD_W-1:0] y_a_i,
  input  logic [COORD_W-1:0] size_a_i,
  input  logic [COORD_W-1:0] x_b_i,
  input  logic [COORD_W-1:0] y_b_i,
  input  logic [COORD_W-1:0] size_b_i,
  output logic               hit_o
);

  assign hit_o = box_hit(x_a_i, y_a_i, size_a_i, x_b_i, y_b_i, size_b_i);

endmodule

// File: rtl/game_state_ctrl.sv
// Game-outcome controller: per-frame ghost collision, lives, frightened window,
// death freeze and win/lose terminal states.
module game_state_ctrl
  import game_pkg::*;
#(
  parameter int unsigned NUM_GHOSTS    = 4,
  parameter int unsigned NUM_PELLETS   = 241,
  parameter int unsigned LIVES_INIT    = 3,
  parameter int unsigned FRIGHT_FRAMES = 360,
  parameter int unsigned DEATH_FRAMES  = 90
) (
  input  logic                            Clk,
  input  logic                            Reset,
  input  logic                            Frame_tick,
  input  logic [NUM_GHOSTS*COORD_W-1:0]   X_ghost,
  input  logic [NUM_GHOSTS*COORD_W-1:0]   Y_ghost,
  input  logic [COORD_W-1:0]              Size_ghost,
  input  logic [COORD_W-1:0]              X_pac,
  input  logic [COORD_W-1:0]              Y_pac,
  input  logic [COORD_W-1:0]              Size_pac,
  input  logic [NUM_PELLETS-1:0]          Not_ate,
  input  logic                            Power_eaten,
  input  logic                            Restart,
  output logic [2:0]                      Lives,
  output logic                            Frightened,
  output logic [NUM_GHOSTS-1:0]           Ghost_eaten,
  output logic                            Kill,
  output logic                            Freeze,
  output logic                            Game_over,
  output logic                            Win
);

  localparam int unsigned FCNT_W = $clog2(FRIGHT_FRAMES + 1);
  localparam int unsigned DCNT_W = $clog2(DEATH_FRAMES + 1);
  localparam logic [FCNT_W-1:0] FRIGHT_LOAD = FCNT_W'(FRIGHT_FRAMES - 1);
  localparam logic [DCNT_W-1:0] DEATH_LOAD  = DCNT_W'(DEATH_FRAMES - 1);
  localparam logic [2:0]        LIVES_RST   = 3'(LIVES_INIT);

  state_e                  state_q, state_d;
  logic [2:0]              lives_q, lives_d;
  logic [FCNT_W-1:0]       fcnt_q, fcnt_d;
  logic [DCNT_W-1:0]       dcnt_q, dcnt_d;
  logic                    fright_q, fright_d;
  logic                    pend_q, pend_d;
  logic                    kill_q, kill_d;
  logic [NUM_GHOSTS-1:0]   geaten_q, geaten_d;
  logic [NUM_GHOSTS-1:0]   hit;
  logic                    pwr;

  for (genvar g = 0; g < NUM_GHOSTS; g++) begin : g_ghost
    box_overlap u_box (
      .x_a_i   (X_pac),
      .y_a_i   (Y_pac),
      .size_a_i(Size_pac),
      .x_b_i   (X_ghost[g*COORD_W +: COORD_W]),
      .y_b_i   (Y_ghost[g*COORD_W +: COORD_W]),
      .size_b_i(Size_ghost),
      .hit_o   (hit[g])
    );
  end

  assign pwr = pend_q | Power_eaten;

  always_comb begin
    state_d  = state_q;
    lives_d  = lives_q;
    fcnt_d   = fcnt_q;
    dcnt_d   = dcnt_q;
    fright_d = fright_q;
    pend_d   = pwr;
    kill_d   = 1'b0;
    geaten_d = '0;
    if (Frame_tick) begin
      // Pending power is consumed on every tick; outside PLAY it is simply dropped.
      pend_d = 1'b0;
      unique case (state_q)
        PLAY: begin
          if (pwr) begin
            fcnt_d   = FRIGHT_LOAD;
            fright_d = 1'b1;
          end else if (fcnt_q != '0) begin
            fcnt_d = fcnt_q - FCNT_W'(1);
          end else begin
            fright_d = 1'b0;
          end
          if (Not_ate == '0) begin
            state_d  = WIN;
            fcnt_d   = '0;
            fright_d = 1'b0;
          end else if ((|hit) && !fright_q) begin
            kill_d   = 1'b1;
            lives_d  = lives_q - 3'd1;
            fcnt_d   = '0;
            fright_d = 1'b0;
            if (lives_q == 3'd1) begin
              state_d = GAME_OVER;
            end else begin
              state_d = DEATH;
              dcnt_d  = DEATH_LOAD;
            end
          end else if (fright_q) begin
            geaten_d = hit;
          end
        end
        DEATH: begin
          if (dcnt_q == '0) state_d = PLAY;
          else dcnt_d = dcnt_q - DCNT_W'(1);
        end
        GAME_OVER, WIN: begin
          if (Restart) begin
            state_d  = PLAY;
            lives_d  = LIVES_RST;
            fcnt_d   = '0;
            dcnt_d   = '0;
            fright_d = 1'b0;
          end
        end
      endcase
    end
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state_q  <= PLAY;
      lives_q  <= LIVES_RST;
      fcnt_q   <= '0;
      dcnt_q   <= '0;
      fright_q <= 1'b0;
      pend_q   <= 1'b0;
      kill_q   <= 1'b0;
      geaten_q <= '0;
    end else begin
      state_q  <= state_d;
      lives_q  <= lives_d;
      fcnt_q   <= fcnt_d;
      dcnt_q   <= dcnt_d;
      fright_q <= fright_d;
      pend_q   <= pend_d;
      kill_q   <= kill_d;
      geaten_q <= geaten_d;
    end
  end

  assign Lives       = lives_q;
  assign Frightened  = fright_q;
  assign Ghost_eaten = geaten_q;
  assign Kill        = kill_q;
  assign Freeze      = (state_q != PLAY);
  assign Game_over   = (state_q == GAME_OVER);
  assign Win         = (state_q == WIN);

endmodule

// File: tb/tb_game_state_ctrl.sv
// Scoreboard bench for game_state_ctrl: driver queues expected outputs per cycle,
// a monitor pops and compares them just after each rising edge.
module tb_game_state_ctrl;

  localparam int unsigned NG = 4;
  localparam int unsigned NP = 241;

  logic              Clk = 1'b0;
  logic              Reset;
  logic              Frame_tick;
  logic [NG*10-1:0]  X_ghost, Y_ghost;
  logic [9:0]        Size_ghost, X_pac, Y_pac, Size_pac;
  logic [NP-1:0]     Not_ate;
  logic              Power_eaten, Restart;
  logic [2:0]        Lives;
  logic              Frightened, Kill, Freeze, Game_over, Win;
  logic [NG-1:0]     Ghost_eaten;

  always #5 Clk = ~Clk;

  game_state_ctrl #(
    .NUM_GHOSTS   (NG),
    .NUM_PELLETS  (NP),
    .LIVES_INIT   (3),
    .FRIGHT_FRAMES(360),
    .DEATH_FRAMES (90)
  ) dut (
    .Clk        (Clk),
    .Reset      (Reset),
    .Frame_tick (Frame_tick),
    .X_ghost    (X_ghost),
    .Y_ghost    (Y_ghost),
    .Size_ghost (Size_ghost),
    .X_pac      (X_pac),
    .Y_pac      (Y_pac),
    .Size_pac   (Size_pac),
    .Not_ate    (Not_ate),
    .Power_eaten(Power_eaten),
    .Restart    (Restart),
    .Lives      (Lives),
    .Frightened (Frightened),
    .Ghost_eaten(Ghost_eaten),
    .Kill       (Kill),
    .Freeze     (Freeze),
    .Game_over  (Game_over),
    .Win        (Win)
  );

  typedef struct {
    string         tag;
    logic [2:0]    lives;
    logic          fr;
    logic [NG-1:0] ge;
    logic          kill;
    logic          frz;
    logic          go;
    logic          win;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  function automatic exp_t mk(input string tag, input logic [2:0] lives, input logic fr,
                              input logic [NG-1:0] ge, input logic kill, input logic frz,
                              input logic go, input logic win);
    exp_t e;
    e.tag = tag; e.lives = lives; e.fr = fr; e.ge = ge;
    e.kill = kill; e.frz = frz; e.go = go; e.win = win;
    return e;
  endfunction

  // Called at a falling edge; inputs hold through the next rising edge.
  task automatic cyc(input logic tick, input logic pwr, input exp_t e);
    Frame_tick  = tick;
    Power_eaten = pwr;
    exp_q.push_back(e);
    @(negedge Clk);
  endtask

  task automatic set_ghost(input int i, input int x, input int y);
    X_ghost[i*10 +: 10] = 10'(x);
    Y_ghost[i*10 +: 10] = 10'(y);
  endtask

  task automatic park();
    for (int i = 0; i < NG; i++) set_ghost(i, 700 + 60 * i, 700);
  endtask

  task automatic death_wait(input logic [2:0] lv);
    for (int i = 1; i < 90; i++) cyc(1'b1, 1'b0, mk("death_freeze", lv, 0, '0, 0, 1, 0, 0));
    cyc(1'b1, 1'b0, mk("death_release", lv, 0, '0, 0, 0, 0, 0));
  endtask

  initial begin
    exp_t e;
    forever begin
      @(posedge Clk);
      #1;
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        n_checks++;
        if (Lives !== e.lives || Frightened !== e.fr || Ghost_eaten !== e.ge || Kill !== e.kill ||
            Freeze !== e.frz || Game_over !== e.go || Win !== e.win) begin
          n_fail++;
          $display("FAIL %s @%0t: got Lives=%0d Fr=%b Ge=%b Kill=%b Freeze=%b Go=%b Win=%b, required Lives=%0d Fr=%b Ge=%b Kill=%b Freeze=%b Go=%b Win=%b",
                   e.tag, $time, Lives, Frightened, Ghost_eaten, Kill, Freeze, Game_over, Win,
                   e.lives, e.fr, e.ge, e.kill, e.frz, e.go, e.win);
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    Reset = 1'b1; Frame_tick = 1'b0; Power_eaten = 1'b0; Restart = 1'b0;
    Size_ghost = 10'd8; Size_pac = 10'd8; Not_ate = '1;
    X_pac = 10'd300; Y_pac = 10'd300;
    X_ghost = '0; Y_ghost = '0;
    park();
    @(negedge Clk);
    cyc(1'b0, 1'b0, mk("reset_values", 3, 0, '0, 0, 0, 0, 0));
    Reset = 1'b0;

    // Touching-edge kill on ghost 2; overlap kept during the freeze to show no re-evaluation.
    set_ghost(2, 100, 100); X_pac = 10'd116; Y_pac = 10'd100;
    cyc(1'b1, 1'b0, mk("kill_tick", 2, 0, '0, 1, 1, 0, 0));
    cyc(1'b0, 1'b0, mk("kill_pulse_end", 2, 0, '0, 0, 1, 0, 0));
    death_wait(3'd2);
    park();

    // Saturating low edge: no wrap-around hit, then a touching hit.
    X_pac = 10'd0; Y_pac = 10'd0;
    set_ghost(0, 1020, 0);
    cyc(1'b1, 1'b0, mk("no_wrap_hit", 2, 0, '0, 0, 0, 0, 0));
    set_ghost(0, 16, 0);
    cyc(1'b1, 1'b0, mk("origin_touch_kill", 1, 0, '0, 1, 1, 0, 0));
    cyc(1'b1, 1'b0, mk("death_mid", 1, 0, '0, 0, 1, 0, 0));
    cyc(1'b1, 1'b0, mk("death_mid", 1, 0, '0, 0, 1, 0, 0));

    // Short asynchronous reset pulse between clock edges in DEATH.
    Frame_tick = 1'b0;
    Reset = 1'b1;
    exp_q.push_back(mk("async_reset_mid_death", 3, 0, '0, 0, 0, 0, 0));
    #2;
    Reset = 1'b0;
    @(negedge Clk);
    park(); X_pac = 10'd300; Y_pac = 10'd300;
    cyc(1'b1, 1'b0, mk("play_after_reset", 3, 0, '0, 0, 0, 0, 0));

    // Power pellet, then simultaneous frightened hits on ghosts 0 and 3.
    cyc(1'b0, 1'b1, mk("power_latched_only", 3, 0, '0, 0, 0, 0, 0));
    cyc(1'b1, 1'b0, mk("fright_start_f0", 3, 1, '0, 0, 0, 0, 0));
    set_ghost(0, 300, 310); set_ghost(3, 290, 300);
    cyc(1'b1, 1'b0, mk("ghost_eaten_f1", 3, 1, 4'b1001, 0, 0, 0, 0));
    cyc(1'b0, 1'b0, mk("ghost_eaten_end", 3, 1, '0, 0, 0, 0, 0));
    park();
    for (int f = 2; f < 300; f++) cyc(1'b1, 1'b0, mk("fright_hold", 3, 1, '0, 0, 0, 0, 0));
    cyc(1'b1, 1'b1, mk("fright_reload_f300", 3, 1, '0, 0, 0, 0, 0));
    for (int f = 301; f < 660; f++) cyc(1'b1, 1'b0, mk("fright_hold2", 3, 1, '0, 0, 0, 0, 0));
    cyc(1'b1, 1'b0, mk("fright_drop_f660", 3, 0, '0, 0, 0, 0, 0));

    // Three unfrightened hits exhaust lives.
    set_ghost(1, 300, 300);
    cyc(1'b1, 1'b0, mk("hit1", 2, 0, '0, 1, 1, 0, 0));
    death_wait(3'd2);
    cyc(1'b1, 1'b0, mk("hit2", 1, 0, '0, 1, 1, 0, 0));
    death_wait(3'd1);
    cyc(1'b1, 1'b0, mk("hit3_game_over", 0, 0, '0, 1, 1, 1, 0));
    cyc(1'b0, 1'b0, mk("game_over_hold", 0, 0, '0, 0, 1, 1, 0));
    cyc(1'b1, 1'b0, mk("game_over_ignores_hit", 0, 0, '0, 0, 1, 1, 0));
    Restart = 1'b1;
    cyc(1'b0, 1'b0, mk("restart_needs_tick", 0, 0, '0, 0, 1, 1, 0));
    cyc(1'b1, 1'b0, mk("restart_to_play", 3, 0, '0, 0, 0, 0, 0));
    Restart = 1'b0;
    park();

    // Win beats Kill on the same tick; power during WIN is discarded.
    Not_ate = '0; set_ghost(2, 300, 300);
    cyc(1'b1, 1'b0, mk("win_over_kill", 3, 0, '0, 0, 1, 0, 1));
    cyc(1'b0, 1'b1, mk("win_power_pulse", 3, 0, '0, 0, 1, 0, 1));
    Not_ate = '1; park();
    cyc(1'b1, 1'b0, mk("win_hold", 3, 0, '0, 0, 1, 0, 1));
    Restart = 1'b1;
    cyc(1'b1, 1'b0, mk("win_restart", 3, 0, '0, 0, 0, 0, 0));
    Restart = 1'b0;
    cyc(1'b1, 1'b0, mk("power_discarded", 3, 0, '0, 0, 0, 0, 0));

    Frame_tick = 1'b0; Power_eaten = 1'b0;
    repeat (2) @(negedge Clk);
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL drain: %0d expectations left, required 0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
